// File: rtl/pingpong_dp_ram.sv
// -----------------------------------------------------------------------------
// pingpong_dp_ram
//
// Purpose:
//   Dual-port RAM with two banks (ping/pong). Both ports access only the
//   active bank. A swap request toggles the active bank at the sampling edge.
//   Accesses sampled at that same edge still use the old bank. Reads already
//   in flight finish with data from the bank they were issued to.
//
// Parameters:
//   DATA_W  - word width in bits
//   ADDR_W  - address width; each bank holds 2**ADDR_W words
//   OUT_REG - 0: read latency 1, 1: extra output register, read latency 2
//
// Ports:
//   i_clk           - single clock, rising edge
//   i_rst_n         - asynchronous active-low reset
//   i_en_a/b        - port access enable
//   i_we_a/b        - write enable (qualified by i_en_x)
//   i_addr_a/b      - word address within the active bank
//   i_data_a/b      - write data
//   o_data_a/b      - read data (holds its last value when no access returns)
//   o_valid_a/b     - o_data_x is valid this cycle
//   i_swap          - request to toggle the active bank
//   o_bank          - index of the active bank
//   o_swap_ack      - one-cycle pulse after a swap takes effect
//   o_wr_collision  - one-cycle pulse after both ports wrote the same address
// -----------------------------------------------------------------------------
module pingpong_dp_ram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int OUT_REG = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en_a,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_data_a,
    output logic [DATA_W-1:0] o_data_a,
    output logic              o_valid_a,
    input  logic              i_en_b,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_data_b,
    output logic [DATA_W-1:0] o_data_b,
    output logic              o_valid_b,
    input  logic              i_swap,
    output logic              o_bank,
    output logic              o_swap_ack,
    output logic              o_wr_collision
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage is deliberately left unreset so it can map onto block RAM.
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    logic              bank_q;
    logic              swap_ack_q;
    logic              coll_q;

    logic              wr_a;
    logic              wr_b;
    logic              dual_wr_same;
    logic              wr_b_eff;

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    logic [DATA_W-1:0] d1_a;
    logic [DATA_W-1:0] d1_b;
    logic              v1_a;
    logic              v1_b;

    assign wr_a         = i_en_a & i_we_a;
    assign wr_b         = i_en_b & i_we_b;
    assign dual_wr_same = wr_a & wr_b & (i_addr_a == i_addr_b);
    // Port A wins a same-address dual write; B's write is dropped.
    assign wr_b_eff     = wr_b & ~dual_wr_same;

    // Combinational array read of the active bank. It is sampled at the edge
    // before this edge's writes land, which gives read-first behaviour across
    // ports.
    always_comb begin
        rd_a = mem0[i_addr_a];
        rd_b = mem0[i_addr_b];
        if (bank_q) begin
            rd_a = mem1[i_addr_a];
            rd_b = mem1[i_addr_b];
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_a) begin
            if (bank_q) mem1[i_addr_a] <= i_data_a;
            else        mem0[i_addr_a] <= i_data_a;
        end
        if (wr_b_eff) begin
            if (bank_q) mem1[i_addr_b] <= i_data_b;
            else        mem0[i_addr_b] <= i_data_b;
        end
    end

    // Bank select, swap acknowledge and collision flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bank_q     <= 1'b0;
            swap_ack_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            if (i_swap) bank_q <= ~bank_q;
            swap_ack_q <= i_swap;
            coll_q     <= dual_wr_same;
        end
    end

    // First read stage. A write returns its own data on the same port, so it
    // is write-first. The data register holds its value when the port is idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d1_a <= '0;
            d1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
        end else begin
            v1_a <= i_en_a;
            v1_b <= i_en_b;
            if (i_en_a) d1_a <= i_we_a ? i_data_a : rd_a;
            if (i_en_b) d1_b <= i_we_b ? i_data_b : rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] d2_a;
            logic [DATA_W-1:0] d2_b;
            logic              v2_a;
            logic              v2_b;

            // Free-running second stage that never stalls.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    d2_a <= '0;
                    d2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    d2_a <= d1_a;
                    d2_b <= d1_b;
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                end
            end

            assign o_data_a  = d2_a;
            assign o_data_b  = d2_b;
            assign o_valid_a = v2_a;
            assign o_valid_b = v2_b;
        end else begin : g_no_out_reg
            assign o_data_a  = d1_a;
            assign o_data_b  = d1_b;
            assign o_valid_a = v1_a;
            assign o_valid_b = v1_b;
        end
    endgenerate

    assign o_bank         = bank_q;
    assign o_swap_ack     = swap_ack_q;
    assign o_wr_collision = coll_q;

endmodule

// File: doc/pingpong_dp_ram.md
PINGPONG_DP_RAM -- requirements
Module: pingpong_dp_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10: address width; each bank holds 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0: 0 gives read latency 1; 1 adds an output register stage, giving read latency 2.
REQ-004 Port i_clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Ports i_en_a / i_en_b, input, 1: port access enable.
REQ-007 Ports i_we_a / i_we_b, input, 1: write enable; qualified by the port enable.
REQ-008 Ports i_addr_a / i_addr_b, input, ADDR_W: word address within the active bank.
REQ-009 Ports i_data_a / i_data_b, input, DATA_W: write data.
REQ-010 Ports o_data_a / o_data_b, output, DATA_W: read data.
REQ-011 Ports o_valid_a / o_valid_b, output, 1: o_data_x is valid this cycle.
REQ-012 Port i_swap, input, 1: request to toggle the active bank.
REQ-013 Port o_bank, output, 1: index of the active bank (0 or 1).
REQ-014 Port o_swap_ack, output, 1: one-cycle pulse when a swap takes effect.
REQ-015 Port o_wr_collision, output, 1: one-cycle pulse when both ports write the same address.

Function
REQ-016 SHALL contain two banks of 2**ADDR_W x DATA_W words; both ports access only bank[o_bank].
REQ-017 A cycle with en=1 and we=1 SHALL write data to bank[o_bank][addr] at that rising edge.
REQ-018 Every enabled access SHALL produce o_valid_x=1, delayed by the read latency; a write access returns the written data (write-first on the same port).
REQ-019 A port read of an address that the other port writes in the same cycle SHALL return the pre-write contents (read-first across ports).
REQ-020 Both ports writing the same address in the same cycle: port A's data SHALL be stored, port B's data discarded.
REQ-021 On that dual-write collision, o_wr_collision SHALL pulse in the following cycle.
REQ-022 Port B's o_data_b for a collided write SHALL still return i_data_b, per REQ-018.
REQ-023 i_swap=1 at an edge SHALL toggle o_bank at that edge, and o_swap_ack SHALL be 1 for the following cycle.
REQ-024 Accesses sampled at the same edge as a swap SHALL use the old bank.
REQ-025 A swap SHALL NOT disturb reads in flight; they complete from their issue bank.
REQ-026 i_swap held high SHALL toggle o_bank every cycle.
REQ-027 With en=0, a port's o_data_x SHALL hold its last value and o_valid_x SHALL be 0 after the latency.
REQ-028 With OUT_REG=1, the valid and data pipelines SHALL advance every cycle (no stall); back-to-back reads are accepted at 1 per cycle per port.
REQ-029 Address range is full 2**ADDR_W with no wrap logic; the top address (all ones) SHALL be fully usable.

Reset
REQ-030 While i_rst_n=0, the block SHALL asynchronously drive: o_data_a/b=0, o_valid_a/b=0, o_bank=0, o_swap_ack=0, o_wr_collision=0, and clear all pipeline stages.
REQ-031 Memory contents SHALL NOT be reset and are undefined until written.
REQ-032 Reset asserted mid-operation SHALL abort in-flight reads (no valid after release) and drop a pending swap.
REQ-033 The first access is honoured at the first rising edge with i_rst_n=1.

Verification
REQ-034 OUT_REG=0, bank 0: A writes 0xDEADBEEF to address 5; next cycle B reads address 5 -> o_data_b=0xDEADBEEF, o_valid_b=1 one cycle later.
REQ-035 Same cycle: A writes 0x11 and B writes 0x22 to address 3 -> o_wr_collision pulses; a later read of address 3 returns 0x11.
REQ-036 Write 0xAA to bank 0 address 0; pulse i_swap; read address 0 -> o_bank=1, o_swap_ack pulses, the read returns bank 1 contents; swap back and read -> 0xAA.
REQ-037 OUT_REG=1: A reads addresses 0,1,2 back-to-back with i_swap asserted in the same cycle as the read of address 0 -> all three o_data_a values arrive 2 cycles after issue; address 0 is read from the old bank, addresses 1 and 2 from the new bank.
REQ-038 Assert i_rst_n=0 asynchronously mid-read with o_bank=1 -> outputs 0 and o_bank=0 immediately; no o_valid after release.
REQ-039 ADDR_W=4: write 0x7 to address 15, then read address 15 -> returns 0x7; address 0 unaffected.
